// File: rtl/music_pkg.sv
// Shared types and ROM word layout for the song playback path.
package music_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_DONE
    } state_t;

    localparam int SONG_W   = 2;
    localparam int NOTE_W   = 8;
    localparam int DUR_W    = 8;
    localparam int WORD_W   = 16;
    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 0;

    localparam logic [DUR_W-1:0]  END_DUR   = 8'd0;
    localparam logic [NOTE_W-1:0] REST_NOTE = 8'd0;

    function automatic logic [NOTE_W-1:0] word_note(
        input logic [WORD_W-1:0] w
    );
        return w[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(
        input logic [WORD_W-1:0] w
    );
        return w[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/note_timer.sv
// Duration down-counter; expire marks the tick that ends a note.
module note_timer
    import music_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] value,
    input  logic             tick,
    input  logic             clear,
    output logic             expire
);

    logic [DUR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = tick & (count == 8'd1);

endmodule

// File: rtl/song_note_reader.sv
// Walks a song in the note ROM and holds each note for its duration.
module song_note_reader
    import music_pkg::*;
#(
    parameter int NOTE_IDX_W = 6,
    parameter int LOOP       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SONG_W-1:0]            select,
    input  logic                         start,
    input  logic                         tick,
    input  logic [WORD_W-1:0]            mem_data,
    output logic [SONG_W+NOTE_IDX_W-1:0] mem_addr,
    output logic [NOTE_W-1:0]            note,
    output logic                         note_valid,
    output logic                         song_done
);

    state_t                       state, state_n;
    logic [SONG_W-1:0]            song, song_n;
    logic [NOTE_IDX_W-1:0]        idx, idx_n;
    logic [SONG_W+NOTE_IDX_W-1:0] addr_n;
    logic [NOTE_W-1:0]            note_n;
    logic                         valid_n;
    logic                         done_n;
    logic                         song_end;
    logic                         t_load;
    logic                         t_clear;
    logic                         t_tick;
    logic                         expire;

    // Timer controls kept outside the FSM block to avoid a comb loop via expire
    assign t_clear = start;
    assign t_tick  = tick & ~start & (state == S_PLAY);
    assign t_load  = ~start & (state == S_WAIT)
                   & (word_dur(mem_data) != END_DUR);

    note_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (t_load),
        .value  (word_dur(mem_data)),
        .tick   (t_tick),
        .clear  (t_clear),
        .expire (expire)
    );

    always_comb begin
        state_n  = state;
        song_n   = song;
        idx_n    = idx;
        addr_n   = mem_addr;
        note_n   = note;
        valid_n  = note_valid;
        done_n   = 1'b0;
        song_end = 1'b0;
        if (start) begin
            song_n  = select;
            idx_n   = '0;
            addr_n  = {select, {NOTE_IDX_W{1'b0}}};
            note_n  = REST_NOTE;
            valid_n = 1'b0;
            state_n = S_FETCH;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                end
                S_FETCH: begin
                    addr_n  = {song, idx};
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (word_dur(mem_data) == END_DUR) begin
                        song_end = 1'b1;
                    end else begin
                        note_n  = word_note(mem_data);
                        valid_n = 1'b1;
                        state_n = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (expire) begin
                        if (&idx) begin
                            song_end = 1'b1;
                        end else begin
                            idx_n   = idx + 1'b1;
                            state_n = S_FETCH;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
            // Index wrap and end marker share the same end-of-song path
            if (song_end) begin
                done_n = 1'b1;
                if (LOOP != 0) begin
                    idx_n   = '0;
                    state_n = S_FETCH;
                end else begin
                    note_n  = REST_NOTE;
                    valid_n = 1'b0;
                    state_n = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            song       <= '0;
            idx        <= '0;
            mem_addr   <= '0;
            note       <= '0;
            note_valid <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            state      <= state_n;
            song       <= song_n;
            idx        <= idx_n;
            mem_addr   <= addr_n;
            note       <= note_n;
            note_valid <= valid_n;
            song_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_song_note_reader.sv
// Directed bench: LOOP=1 instance (dut0) and LOOP=0 instance (dut1).
module tb_song_note_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  select;
    logic        start;
    logic        tick;
    logic [15:0] rom [256];
    logic [15:0] mem_data0, mem_data1;
    logic [7:0]  mem_addr0, mem_addr1;
    logic [7:0]  note0, note1;
    logic        note_valid0, note_valid1;
    logic        song_done0, song_done1;

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    bit cnt_en = 1'b0;

    always #5 clk = ~clk;

    assign mem_data0 = rom[mem_addr0];
    assign mem_data1 = rom[mem_addr1];

    song_note_reader #(.NOTE_IDX_W(6), .LOOP(1)) dut0 (
        .clk(clk), .reset(reset), .select(select), .start(start),
        .tick(tick), .mem_data(mem_data0), .mem_addr(mem_addr0),
        .note(note0), .note_valid(note_valid0), .song_done(song_done0)
    );

    song_note_reader #(.NOTE_IDX_W(6), .LOOP(0)) dut1 (
        .clk(clk), .reset(reset), .select(select), .start(start),
        .tick(tick), .mem_data(mem_data1), .mem_addr(mem_addr1),
        .note(note1), .note_valid(note_valid1), .song_done(song_done1)
    );

    always @(negedge clk) if (cnt_en) done_cnt += int'(song_done1);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick;
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (mem_addr0 !== 8'h00) begin fails++;
            $display("FAIL rst_addr: got %h want 00", mem_addr0); end
        checks++;
        if (note0 !== 8'h00) begin fails++;
            $display("FAIL rst_note: got %h want 00", note0); end
        checks++;
        if (note_valid0 !== 1'b0 || note_valid1 !== 1'b0) begin fails++;
            $display("FAIL rst_valid: got %b/%b want 0/0", note_valid0, note_valid1); end
        checks++;
        if (song_done0 !== 1'b0 || song_done1 !== 1'b0) begin fails++;
            $display("FAIL rst_done: got %b/%b want 0/0", song_done0, song_done1); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_song2;
        select = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (mem_addr0 !== 8'h80) begin fails++;
            $display("FAIL s2_addr: got %h want 80", mem_addr0); end
        checks++;
        if (note_valid0 !== 1'b0) begin fails++;
            $display("FAIL s2_early_valid: got %b want 0", note_valid0); end
        step();
        checks++;
        if (note0 !== 8'h3C || note_valid0 !== 1'b1) begin fails++;
            $display("FAIL s2_note: got %h/%b want 3c/1", note0, note_valid0); end
        do_tick();
        do_tick();
        step();
        checks++;
        if (mem_addr0 !== 8'h81) begin fails++;
            $display("FAIL s2_next_addr: got %h want 81", mem_addr0); end
        checks++;
        if (note0 !== 8'h3C || note_valid0 !== 1'b1) begin fails++;
            $display("FAIL s2_hold: got %h/%b want 3c/1", note0, note_valid0); end
        step();
        checks++;
        if (song_done0 !== 1'b1) begin fails++;
            $display("FAIL s2_done: got %b want 1", song_done0); end
        step();
        checks++;
        if (song_done0 !== 1'b0 || mem_addr0 !== 8'h80) begin fails++;
            $display("FAIL s2_loop: got done=%b addr=%h want 0/80", song_done0, mem_addr0); end
    endtask

    task automatic test_rest;
        select = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (mem_addr0 !== 8'h00) begin fails++;
            $display("FAIL r_addr0: got %h want 00", mem_addr0); end
        step();
        checks++;
        if (note0 !== 8'h40 || note_valid0 !== 1'b1) begin fails++;
            $display("FAIL r_note0: got %h/%b want 40/1", note0, note_valid0); end
        repeat (4) do_tick();
        step();
        checks++;
        if (mem_addr0 !== 8'h00 || note0 !== 8'h40) begin fails++;
            $display("FAIL r_dur5: got addr=%h note=%h want 00/40", mem_addr0, note0); end
        do_tick();
        step();
        checks++;
        if (mem_addr0 !== 8'h01) begin fails++;
            $display("FAIL r_addr1: got %h want 01", mem_addr0); end
        step();
        checks++;
        if (note0 !== 8'h00 || note_valid0 !== 1'b1) begin fails++;
            $display("FAIL r_rest: got %h/%b want 00/1", note0, note_valid0); end
        do_tick();
        do_tick();
        step();
        checks++;
        if (mem_addr0 !== 8'h01) begin fails++;
            $display("FAIL r_rest_hold: got %h want 01", mem_addr0); end
        do_tick();
        step();
        checks++;
        if (mem_addr0 !== 8'h02) begin fails++;
            $display("FAIL r_addr2: got %h want 02", mem_addr0); end
        step();
        checks++;
        if (note0 !== 8'h42 || note_valid0 !== 1'b1) begin fails++;
            $display("FAIL r_note2: got %h/%b want 42/1", note0, note_valid0); end
    endtask

    task automatic test_start_mid;
        select = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (note_valid0 !== 1'b0 || mem_addr0 !== 8'h40) begin fails++;
            $display("FAIL mid_drop: got valid=%b addr=%h want 0/40", note_valid0, mem_addr0); end
        step();
        step();
        checks++;
        if (note0 !== 8'h50 || note_valid0 !== 1'b1) begin fails++;
            $display("FAIL mid_note: got %h/%b want 50/1", note0, note_valid0); end
    endtask

    task automatic test_start_tick;
        select = 2'd2;
        start = 1'b1;
        tick = 1'b1;
        step();
        start = 1'b0;
        tick = 1'b0;
        step();
        checks++;
        if (mem_addr0 !== 8'h80) begin fails++;
            $display("FAIL st_addr: got %h want 80", mem_addr0); end
        step();
        checks++;
        if (note0 !== 8'h3C || note_valid0 !== 1'b1) begin fails++;
            $display("FAIL st_note: got %h/%b want 3c/1", note0, note_valid0); end
        do_tick();
        step();
        step();
        checks++;
        if (mem_addr0 !== 8'h80 || note0 !== 8'h3C) begin fails++;
            $display("FAIL st_full_dur: got addr=%h note=%h want 80/3c", mem_addr0, note0); end
        do_tick();
        step();
        checks++;
        if (mem_addr0 !== 8'h81) begin fails++;
            $display("FAIL st_end: got %h want 81", mem_addr0); end
    endtask

    task automatic test_loop0;
        logic [7:0] exp_addr;
        logic [7:0] exp_note;
        select = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cnt = 0;
        cnt_en = 1'b1;
        step();
        step();
        checks++;
        if (note1 !== 8'h01 || note_valid1 !== 1'b1) begin fails++;
            $display("FAIL l0_first: got %h/%b want 01/1", note1, note_valid1); end
        for (int i = 0; i < 63; i++) begin
            exp_addr = 8'hC0 + 8'(i) + 8'd1;
            exp_note = 8'(i) + 8'd2;
            do_tick();
            step();
            checks++;
            if (mem_addr1 !== exp_addr) begin fails++;
                $display("FAIL l0_addr%0d: got %h want %h", i, mem_addr1, exp_addr); end
            step();
            checks++;
            if (note1 !== exp_note || note_valid1 !== 1'b1) begin fails++;
                $display("FAIL l0_note%0d: got %h/%b want %h/1", i, note1, note_valid1, exp_note); end
        end
        do_tick();
        checks++;
        if (song_done1 !== 1'b1 || note_valid1 !== 1'b0 || note1 !== 8'h00) begin fails++;
            $display("FAIL l0_wrap: got done=%b valid=%b note=%h want 1/0/00",
                     song_done1, note_valid1, note1); end
        repeat (3) do_tick();
        step();
        cnt_en = 1'b0;
        checks++;
        if (done_cnt !== 1) begin fails++;
            $display("FAIL l0_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (note_valid1 !== 1'b0 || mem_addr1 !== 8'hFF) begin fails++;
            $display("FAIL l0_in_done: got valid=%b addr=%h want 0/ff", note_valid1, mem_addr1); end
        select = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (mem_addr1 !== 8'hC0) begin fails++;
            $display("FAIL l0_replay_addr: got %h want c0", mem_addr1); end
        step();
        checks++;
        if (note1 !== 8'h01 || note_valid1 !== 1'b1) begin fails++;
            $display("FAIL l0_replay_note: got %h/%b want 01/1", note1, note_valid1); end
    endtask

    task automatic test_reset_mid;
        step();
        checks++;
        if (note_valid0 !== 1'b1) begin fails++;
            $display("FAIL rm_pre: got %b want 1", note_valid0); end
        reset = 1'b0;
        select = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (mem_addr0 !== 8'h00 || note0 !== 8'h00 || note_valid0 !== 1'b0
            || song_done0 !== 1'b0) begin fails++;
            $display("FAIL rm_outs: got addr=%h note=%h valid=%b done=%b want 0s",
                     mem_addr0, note0, note_valid0, song_done0); end
        step();
        reset = 1'b1;
        step();
        step();
        step();
        checks++;
        if (mem_addr0 !== 8'h00 || note_valid0 !== 1'b0 || note_valid1 !== 1'b0) begin fails++;
            $display("FAIL rm_start_ignored: got addr=%h valid=%b/%b want 00/0/0",
                     mem_addr0, note_valid0, note_valid1); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[8'h00] = 16'h4005;
        rom[8'h01] = 16'h0003;
        rom[8'h02] = 16'h4202;
        rom[8'h40] = 16'h5001;
        rom[8'h80] = 16'h3C02;
        for (int i = 0; i < 64; i++) rom[8'hC0 + i] = {8'(i + 1), 8'h01};
        reset = 1'b0;
        select = 2'd0;
        start = 1'b0;
        tick = 1'b0;
        test_reset();
        test_song2();
        test_rest();
        test_start_mid();
        test_start_tick();
        test_loop0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
